// File: rtl/memory_access_controller.sv
// memory_access_controller
// Single-outstanding bridge from the CPU load/store path to a wait-stated
// memory. A request is accepted in IDLE, the memory strobe is held through
// WAIT until mem_ready, and RESP emits a one-cycle rsp_valid plus a
// count_access pulse for memory_access_register.
//
// Optional feature: define MEM_TIMEOUT_EN to abort an access after TIMEOUT
// WAIT cycles without mem_ready (rsp_error=1, no count_access). Without the
// macro WAIT is unbounded and rsp_error is tied low.
module memory_access_controller #(
  parameter int unsigned ADDR_W  = 16,
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_error,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic              count_access
);

  typedef enum logic [1:0] {
    StIdle,
    StWait,
    StResp
  } state_e;

  state_e state_q;

`ifdef MEM_TIMEOUT_EN
  // Wide enough to hold TIMEOUT itself; reaching 1 with no mem_ready means
  // this WAIT cycle is the last one allowed.
  localparam int unsigned CntW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  logic [CntW-1:0] tmo_cnt_q;
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT;
  assign rsp_error      = 1'b0;
`endif

  // Ready is the only combinational output; masked by reset so the CPU never
  // sees an accept window while the controller is being cleared.
  assign req_ready = (state_q == StIdle) && !reset;

  // FSM with registered memory-side and response-side outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StIdle;
      mem_en       <= 1'b0;
      mem_we       <= 1'b0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
      rsp_valid    <= 1'b0;
      rsp_rdata    <= '0;
      count_access <= 1'b0;
`ifdef MEM_TIMEOUT_EN
      rsp_error    <= 1'b0;
      tmo_cnt_q    <= '0;
`endif
    end else begin
      unique case (state_q)
        StIdle: begin
          if (req_valid) begin
            mem_en    <= 1'b1;
            mem_we    <= req_write;
            mem_addr  <= req_addr;
            mem_wdata <= req_wdata;
`ifdef MEM_TIMEOUT_EN
            tmo_cnt_q <= CntW'(TIMEOUT);
`endif
            state_q   <= StWait;
          end
        end
        StWait: begin
          // mem_ready takes priority over expiry in the same cycle.
          if (mem_ready) begin
            mem_en       <= 1'b0;
            mem_we       <= 1'b0;
            if (!mem_we) begin
              rsp_rdata <= mem_rdata;
            end
            rsp_valid    <= 1'b1;
            count_access <= 1'b1;
            state_q      <= StResp;
          end
`ifdef MEM_TIMEOUT_EN
          else if (tmo_cnt_q == CntW'(1)) begin
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            rsp_valid <= 1'b1;
            rsp_error <= 1'b1;
            state_q   <= StResp;
          end else begin
            tmo_cnt_q <= tmo_cnt_q - CntW'(1);
          end
`endif
        end
        StResp: begin
          rsp_valid    <= 1'b0;
          count_access <= 1'b0;
`ifdef MEM_TIMEOUT_EN
          rsp_error    <= 1'b0;
`endif
          state_q      <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_memory_access_controller.sv
// Scoreboard bench for memory_access_controller: stimulus pushes the expected
// response at acceptance, a negedge monitor pops and compares on each
// rsp_valid/count_access.
module tb_memory_access_controller;

  localparam int unsigned AW  = 16;
  localparam int unsigned DW  = 16;
  localparam int unsigned TMO = 16;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic          req_write = 1'b0;
  logic [AW-1:0] req_addr = '0;
  logic [DW-1:0] req_wdata = '0;
  logic          rsp_valid;
  logic [DW-1:0] rsp_rdata;
  logic          rsp_error;
  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata = '0;
  logic          mem_ready = 1'b0;
  logic          count_access;

  memory_access_controller #(
    .ADDR_W (AW),
    .DATA_W (DW),
    .TIMEOUT(TMO)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_write   (req_write),
    .req_addr    (req_addr),
    .req_wdata   (req_wdata),
    .rsp_valid   (rsp_valid),
    .rsp_rdata   (rsp_rdata),
    .rsp_error   (rsp_error),
    .mem_en      (mem_en),
    .mem_we      (mem_we),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_rdata   (mem_rdata),
    .mem_ready   (mem_ready),
    .count_access(count_access)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [DW-1:0] rdata;
    logic          err;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   checks = 0;
  int   errors = 0;
  int   access_cnt = 0;  // stands in for memory_access_register
  int   pulse_cyc[$];
  bit   mon_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every response or count pulse must match the oldest expectation.
  always @(negedge clk) begin
    if (mon_en && (rsp_valid === 1'b1 || count_access === 1'b1)) begin
      if (count_access === 1'b1) begin
        access_cnt++;
        pulse_cyc.push_back(cyc);
      end
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_rsp: rsp_valid=%0b count_access=%0b, required no response",
                 rsp_valid, count_access);
      end else begin
        e = sb.pop_front();
        check("rsp_valid", {31'd0, rsp_valid}, 32'd1);
        check("rsp_rdata", {16'd0, rsp_rdata}, {16'd0, e.rdata});
        check("rsp_error", {31'd0, rsp_error}, {31'd0, e.err});
        check("count_access", {31'd0, count_access}, {31'd0, ~e.err});
      end
    end
  end

  // Wait (at negedges) for req_ready; the following posedge accepts.
  task automatic wait_ready();
    int n;
    n = 0;
    while (req_ready !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("accept_bound", {31'd0, n < 20}, 32'd1);
  endtask

  // One access with a given number of wait states. Starts and ends on a negedge;
  // ends on the RESP cycle.
  task automatic access(input bit wr, input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                        input int waits, input logic [DW-1:0] rdata,
                        input logic [DW-1:0] exp_rdata, input bit hold);
    req_valid = 1'b1;
    req_write = wr;
    req_addr  = addr;
    req_wdata = wdata;
    wait_ready();
    sb.push_back('{rdata: exp_rdata, err: 1'b0});
    @(negedge clk);
    if (!hold) req_valid = 1'b0;
    for (int i = 0; i <= waits; i++) begin
      check("mem_en_held", {31'd0, mem_en}, 32'd1);
      check("mem_we", {31'd0, mem_we}, {31'd0, wr});
      check("mem_addr", {16'd0, mem_addr}, {16'd0, addr});
      if (wr) check("mem_wdata", {16'd0, mem_wdata}, {16'd0, wdata});
      if (i == waits) begin
        mem_ready = 1'b1;
        mem_rdata = rdata;
      end
      @(negedge clk);
    end
    mem_ready = 1'b0;
    mem_rdata = 16'hDEAD;
    check("mem_en_drop", {31'd0, mem_en}, 32'd0);
    check("rsp_latency", {31'd0, rsp_valid}, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  initial begin
    int a0;
    int p0;

    // 1. Reset for two cycles.
    @(negedge clk);
    mon_en = 1'b1;
    @(negedge clk);
    check("rst_mem_en", {31'd0, mem_en}, 32'd0);
    check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("rst_count", {31'd0, count_access}, 32'd0);
    check("rst_rdata", {16'd0, rsp_rdata}, 32'd0);
    check("rst_req_ready", {31'd0, req_ready}, 32'd0);
    reset = 1'b0;
    @(negedge clk);
    check("post_rst_ready", {31'd0, req_ready}, 32'd1);

    // 2. Zero-wait read.
    access(1'b0, 16'h0010, 16'h0000, 0, 16'hBEEF, 16'hBEEF, 1'b0);

    // 3. Write with three wait states; rsp_rdata keeps 0xBEEF.
    access(1'b1, 16'h0020, 16'h1234, 3, 16'h5555, 16'hBEEF, 1'b0);
    @(negedge clk);
    @(negedge clk);
    check("rdata_hold_after_write", {16'd0, rsp_rdata}, 32'h0000_BEEF);

    // 4. Five back-to-back zero-wait reads with req_valid held.
    a0 = access_cnt;
    p0 = pulse_cyc.size();
    for (int k = 0; k < 5; k++) begin
      access(1'b0, 16'h0100 + 16'(k), 16'h0000, 0, 16'h1001 + 16'(k), 16'h1001 + 16'(k), 1'b1);
    end
    req_valid = 1'b0;
    @(negedge clk);
    check("b2b_count", access_cnt - a0, 32'd5);
    if (pulse_cyc.size() >= p0 + 5) begin
      for (int k = 1; k < 5; k++) begin
        check("b2b_spacing", pulse_cyc[p0 + k] - pulse_cyc[p0 + k - 1], 32'd3);
      end
    end

    // 5. Reset in the second WAIT cycle kills the access.
    a0 = access_cnt;
    req_valid = 1'b1;
    req_write = 1'b0;
    req_addr  = 16'h0030;
    wait_ready();
    @(negedge clk);
    req_valid = 1'b0;
    check("rst_mid_wait1", {31'd0, mem_en}, 32'd1);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("rst_mid_mem_en", {31'd0, mem_en}, 32'd0);
    check("rst_mid_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("rst_mid_req_ready", {31'd0, req_ready}, 32'd0);
    reset = 1'b0;
    @(negedge clk);
    check("rst_mid_ready_after", {31'd0, req_ready}, 32'd1);
    check("rst_mid_mem_en_after", {31'd0, mem_en}, 32'd0);
    check("rst_mid_rdata", {16'd0, rsp_rdata}, 32'd0);
    check("rst_mid_no_count", access_cnt - a0, 32'd0);

    // Recovery read after the killed access.
    access(1'b0, 16'h0031, 16'h0000, 1, 16'h7777, 16'h7777, 1'b0);
    @(negedge clk);

`ifdef MEM_TIMEOUT_EN
    // 6. Memory never answers: abort after TIMEOUT strobe cycles.
    a0 = access_cnt;
    req_valid = 1'b1;
    req_write = 1'b0;
    req_addr  = 16'h0040;
    wait_ready();
    sb.push_back('{rdata: 16'h7777, err: 1'b1});
    @(negedge clk);
    req_valid = 1'b0;
    for (int i = 0; i < int'(TMO); i++) begin
      check("tmo_mem_en_held", {31'd0, mem_en}, 32'd1);
      @(negedge clk);
    end
    check("tmo_mem_en_drop", {31'd0, mem_en}, 32'd0);
    check("tmo_rsp_valid", {31'd0, rsp_valid}, 32'd1);
    @(negedge clk);
    check("tmo_err_clear", {31'd0, rsp_error}, 32'd0);
    check("tmo_no_count", access_cnt - a0, 32'd0);
`endif

    repeat (3) @(negedge clk);
    check("sb_drained", sb.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
